// File: rtl/fan_pkg.sv
// Shared fan definitions: state codes, duty levels, ramp state encoding.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package fan_pkg;

    // Fan-state codes produced by the upstream fan-speed FSM
    localparam logic [2:0] FAN_OFF = 3'd0;
    localparam logic [2:0] FAN_200 = 3'd1;
    localparam logic [2:0] FAN_400 = 3'd2;
    localparam logic [2:0] FAN_600 = 3'd3;
    localparam logic [2:0] FAN_800 = 3'd4;

    // Duty levels in percent
    localparam logic [6:0] DUTY_OFF = 7'd0;
    localparam logic [6:0] DUTY_25  = 7'd25;
    localparam logic [6:0] DUTY_50  = 7'd50;
    localparam logic [6:0] DUTY_75  = 7'd75;
    localparam logic [6:0] DUTY_100 = 7'd100;

    // Last count of a PWM period (period is 100 counts)
    localparam logic [6:0] PWM_LAST = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_state_e;

    // Unused codes 5..7 fall back to off so a corrupted code never spins the fan up
    function automatic logic [6:0] fan_state_to_duty(input logic [2:0] code);
        logic [6:0] duty;
        case (code)
            FAN_OFF: duty = DUTY_OFF;
            FAN_200: duty = DUTY_25;
            FAN_400: duty = DUTY_50;
            FAN_600: duty = DUTY_75;
            FAN_800: duty = DUTY_100;
            default: duty = DUTY_OFF;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: 100-count period, duty latched at each period start, registered output.
// Latency: new i_duty appears on o_pwm from the next period start plus one cycle.
// Backpressure: none; free-running, i_duty sampled only at the 99->0 wrap.
module fan_pwm_gen #(
    parameter int PWM_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_duty,
    output logic       o_pwm
);
    import fan_pkg::*;

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [6:0]       applied_q, applied_d;
    logic             pwm_q, pwm_d;
    logic             div_wrap;

    // Next-state: divider, period counter, and boundary-only duty latch
    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        div_d     = div_wrap ? '0 : div_q + 1'b1;
        cnt_d     = cnt_q;
        applied_d = applied_q;
        if (div_wrap) begin
            if (cnt_q == PWM_LAST) begin
                cnt_d     = '0;
                applied_d = i_duty;
            end else begin
                cnt_d = cnt_q + 7'd1;
            end
        end
        // Duty 100 keeps this true for every count 0..99, so no low pulse
        pwm_d = (cnt_q < applied_q);
    end

    // State registers; reset forces the motor drive low without waiting for a clock
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q     <= '0;
            cnt_q     <= '0;
            applied_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            pwm_q     <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: maps fan-state code to a duty target and soft-ramps duty 1 % per ramp tick.
// Latency: busy/state react 2 cycles after i_fanState; first step RAMP_DIV cycles later.
// Backpressure: none; i_fanState sampled every cycle, PWM output free-running.
module fan_pwm_driver #(
    parameter int PWM_DIV  = 1,
    parameter int RAMP_DIV = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_fanState,
    output logic       o_pwm,
    output logic [6:0] o_duty,
    output logic       o_busy
);
    import fan_pkg::*;

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    ramp_state_e      state_q, state_d;
    logic [6:0]       target_q, target_d;
    logic [6:0]       duty_q, duty_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             ramp_tick;

    // Next-state: step duty on a tick, then classify against the post-step duty so
    // busy drops on the same edge the final step lands
    always_comb begin
        target_d  = fan_state_to_duty(i_fanState);
        ramp_tick = (presc_q == PRE_LAST);
        duty_d    = duty_q;
        // Guard on target keeps a stale direction (target just reversed) from stepping away
        if (ramp_tick && (state_q == ST_RAMP_UP) && (target_q > duty_q)) begin
            duty_d = duty_q + 7'd1;
        end else if (ramp_tick && (state_q == ST_RAMP_DOWN) && (target_q < duty_q)) begin
            duty_d = duty_q - 7'd1;
        end

        if (target_q > duty_d) begin
            state_d = ST_RAMP_UP;
        end else if (target_q < duty_d) begin
            state_d = ST_RAMP_DOWN;
        end else if (duty_d == DUTY_OFF) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_RUN;
        end

        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);

        // Prescaler restarts when entering a ramp or reversing; same-direction
        // target changes leave it running
        if (!busy_d || (state_d != state_q) || ramp_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Ramp FSM with registered outputs; reset abandons any ramp instantly
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            duty_q   <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            presc_q  <= presc_d;
            busy_q   <= busy_d;
        end
    end

    fan_pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_duty  (duty_q),
        .o_pwm   (o_pwm)
    );

    assign o_duty = duty_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver: directed scenarios plus random fan-state sequences vs a reference model.
// Latency: model advances once per clock edge, outputs checked 1 time unit after the edge.
// Backpressure: n/a.
module tb_fan_pwm_driver;

    localparam int PWM_DIV  = 1;
    localparam int RAMP_DIV = 4;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [2:0] i_fanState = 3'd0;
    logic       o_pwm;
    logic [6:0] o_duty;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: target %, current duty %, ramp direction, cycles spent in
    // the current direction, position in PWM period, duty in force this period
    int m_target, m_duty, m_dir, m_elapsed, m_pos, m_applied, m_pwm;

    fan_pwm_driver #(
        .PWM_DIV  (PWM_DIV),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_fanState (i_fanState),
        .o_pwm      (o_pwm),
        .o_duty     (o_duty),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pct_of(input int code);
        return (code >= 1 && code <= 4) ? code * 25 : 0;
    endfunction

    task automatic model_reset();
        m_target = 0; m_duty = 0; m_dir = 0; m_elapsed = 0;
        m_pos = 0; m_applied = 0; m_pwm = 0;
    endtask

    // One clock edge of the specified behaviour, all updates from pre-edge values
    task automatic model_edge();
        int new_duty, new_dir, new_pwm;
        new_duty = m_duty;
        // Every RAMP_DIV-th cycle of a ramp moves duty 1 % toward the target
        if (m_dir != 0 && (m_elapsed % RAMP_DIV) == RAMP_DIV - 1) begin
            if (m_dir > 0 && m_target > m_duty) new_duty = m_duty + 1;
            if (m_dir < 0 && m_target < m_duty) new_duty = m_duty - 1;
        end
        new_dir = (m_target > new_duty) ? 1 : (m_target < new_duty) ? -1 : 0;
        m_elapsed = (new_dir != 0 && new_dir == m_dir) ? m_elapsed + 1 : 0;
        new_pwm = (m_pos < m_applied) ? 1 : 0;
        if (m_pos == 99) begin
            m_applied = m_duty;
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
        m_pwm = new_pwm;
        m_duty = new_duty;
        m_dir = new_dir;
        m_target = pct_of(int'(i_fanState));
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_reset) model_reset();
        else model_edge();
        #1;
        check("duty", o_duty, m_duty);
        check("busy", o_busy, (m_dir != 0));
        check("pwm", o_pwm, m_pwm);
    endtask

    task automatic settle(input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        check("settle_busy", o_busy, 0);
    endtask

    task automatic wait_duty(input int val, input int budget);
        int n;
        n = 0;
        while (int'(o_duty) != val && n < budget) begin
            tick();
            n++;
        end
        check("wait_duty", o_duty, val);
    endtask

    task automatic count_high(input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            tick();
            if (o_pwm) hi++;
        end
    endtask

    initial begin
        int hi, k, latched, mid;
        model_reset();
        // Reset state
        #1;
        check("rst_pwm", o_pwm, 0);
        check("rst_duty", o_duty, 0);
        check("rst_busy", o_busy, 0);
        repeat (3) tick();
        i_reset = 1'b0;
        repeat (500) tick();
        check("idle_pwm", o_pwm, 0);
        check("idle_duty", o_duty, 0);

        // Ramp up to 50 %
        i_fanState = 3'd2;
        for (int i = 1; i <= 202; i++) begin
            tick();
            if (i == 1) check("up_busy_n1", o_busy, 0);
            if (i == 2) check("up_busy_n2", o_busy, 1);
            if (i == 5) check("up_duty_n5", o_duty, 0);
            if (i == 6) check("up_duty_n6", o_duty, 1);
            if (i == 201) check("up_duty_n201", o_duty, 49);
            if (i == 202) begin
                check("up_duty_n202", o_duty, 50);
                check("up_busy_n202", o_busy, 0);
            end
        end
        repeat (200) tick();
        count_high(100, hi);
        check("hi_50", hi, 50);

        // Full on, then invalid code ramps down to off
        i_fanState = 3'd4;
        settle(1000);
        check("full_duty", o_duty, 100);
        repeat (200) tick();
        count_high(100, hi);
        check("hi_100", hi, 100);
        i_fanState = 3'd7;
        settle(1000);
        check("off_duty", o_duty, 0);
        repeat (200) tick();
        count_high(100, hi);
        check("hi_0", hi, 0);

        // Reversal at 30 %
        i_fanState = 3'd4;
        wait_duty(30, 400);
        i_fanState = 3'd1;
        k = 0;
        while (o_duty == 7'd30 && k < 50) begin
            tick();
            k++;
        end
        check("rev_step", o_duty, 29);
        check("rev_delay", k, 6);
        settle(500);
        check("rev_final", o_duty, 25);

        // Boundary latch: high count follows duty latched at period start
        i_fanState = 3'd3;
        repeat (30) tick();
        k = 0;
        while (m_pos != 0 && k < 200) begin
            tick();
            k++;
        end
        latched = m_applied;
        hi = 0;
        mid = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_pwm) hi++;
            if (i == 50) mid = int'(o_duty);
        end
        check("latch_hi", hi, latched);
        check("latch_not_mid", (hi != mid), 1);
        settle(500);
        check("latch_final", o_duty, 75);

        // Asynchronous reset mid-ramp
        i_fanState = 3'd0;
        wait_duty(40, 400);
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_pwm", o_pwm, 0);
        check("arst_duty", o_duty, 0);
        check("arst_busy", o_busy, 0);
        model_reset();
        repeat (2) tick();
        i_reset = 1'b0;
        i_fanState = 3'd3;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 5) check("restart_n5", o_duty, 0);
            if (i == 6) check("restart_n6", o_duty, 1);
        end
        settle(500);
        check("restart_final", o_duty, 75);

        // Random fan-state sequences with occasional resets
        for (int s = 0; s < 30; s++) begin
            i_fanState = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                i_reset = 1'b1;
                repeat (2) tick();
                i_reset = 1'b0;
            end
            repeat ($urandom_range(1, 400)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
